// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared widths and operand-source codes for the CPU pipeline |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_EX   = 2'b10,
    FWD_ZERO = 2'b11
  } fwd_t;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fetch_stage_if: control, bypass and operand-bundle signals   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface operand_fetch_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  stall;
  logic                  flush;
  logic                  valid_in;
  logic [REG_ADDR_W-1:0] rs1_sel_in;
  logic [REG_ADDR_W-1:0] rs2_sel_in;
  logic [REG_ADDR_W-1:0] rd_sel_in;
  logic                  ex_write_enable;
  logic [REG_ADDR_W-1:0] ex_rd_sel;
  logic [XLEN-1:0]       ex_alu_result;
  logic                  wb_write_enable;
  logic [REG_ADDR_W-1:0] wb_rd_sel;
  logic [XLEN-1:0]       wb_value;
  logic                  valid_out;
  logic [XLEN-1:0]       rs1_value_out;
  logic [XLEN-1:0]       rs2_value_out;
  logic [REG_ADDR_W-1:0] rd_sel_out;
  logic [1:0]            fwd_rs1_out;
  logic [1:0]            fwd_rs2_out;

  // master: upstream pipeline driving the stage
  modport master (
    output stall, flush, valid_in, rs1_sel_in, rs2_sel_in, rd_sel_in,
           ex_write_enable, ex_rd_sel, ex_alu_result,
           wb_write_enable, wb_rd_sel, wb_value,
    input  valid_out, rs1_value_out, rs2_value_out, rd_sel_out,
           fwd_rs1_out, fwd_rs2_out
  );

  modport slave (
    input  stall, flush, valid_in, rs1_sel_in, rs2_sel_in, rd_sel_in,
           ex_write_enable, ex_rd_sel, ex_alu_result,
           wb_write_enable, wb_rd_sel, wb_value,
    output valid_out, rs1_value_out, rs2_value_out, rd_sel_out,
           fwd_rs1_out, fwd_rs2_out
  );

endinterface
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_2r1w: 2 async read / 1 sync write register file, x0 == 0     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_2r1w #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  we,
  input  wire logic [REG_ADDR_W-1:0] waddr,
  input  wire logic [XLEN-1:0]       wdata,
  input  wire logic [REG_ADDR_W-1:0] raddr1,
  input  wire logic [REG_ADDR_W-1:0] raddr2,
  output      logic [XLEN-1:0]       rdata1,
  output      logic [XLEN-1:0]       rdata2
);

  localparam int DEPTH = 1 << REG_ADDR_W;

  logic [XLEN-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fetch_stage: regfile read, EX/WB bypass, registered operands |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module operand_fetch_stage #(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input wire logic              clk,
  input wire logic              rst,
  operand_fetch_stage_if.slave  bus
);

  import cpu_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_q, rs2_q;
  logic [REG_ADDR_W-1:0] rs1_eff, rs2_eff;
  logic [XLEN-1:0]       rf_rs1, rf_rs2;
  logic [XLEN-1:0]       rs1_val, rs2_val;
  fwd_t                  rs1_code, rs2_code;

  // A stalled instruction keeps re-resolving its own selects so the operand
  // tracks the producer as it drains EX -> WB -> register file.
  assign rs1_eff = bus.stall ? rs1_q : bus.rs1_sel_in;
  assign rs2_eff = bus.stall ? rs2_q : bus.rs2_sel_in;

  regfile_2r1w #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.wb_write_enable),
    .waddr  (bus.wb_rd_sel),
    .wdata  (bus.wb_value),
    .raddr1 (rs1_eff),
    .raddr2 (rs2_eff),
    .rdata1 (rf_rs1),
    .rdata2 (rf_rs2)
  );

  always_comb begin
    rs1_val  = rf_rs1;
    rs1_code = FWD_RF;
    if (rs1_eff == '0) begin
      rs1_val  = '0;
      rs1_code = FWD_ZERO;
    end else if (bus.ex_write_enable && (bus.ex_rd_sel == rs1_eff)) begin
      rs1_val  = bus.ex_alu_result;
      rs1_code = FWD_EX;
    end else if (bus.wb_write_enable && (bus.wb_rd_sel == rs1_eff)) begin
      rs1_val  = bus.wb_value;
      rs1_code = FWD_WB;
    end
  end

  always_comb begin
    rs2_val  = rf_rs2;
    rs2_code = FWD_RF;
    if (rs2_eff == '0) begin
      rs2_val  = '0;
      rs2_code = FWD_ZERO;
    end else if (bus.ex_write_enable && (bus.ex_rd_sel == rs2_eff)) begin
      rs2_val  = bus.ex_alu_result;
      rs2_code = FWD_EX;
    end else if (bus.wb_write_enable && (bus.wb_rd_sel == rs2_eff)) begin
      rs2_val  = bus.wb_value;
      rs2_code = FWD_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bus.valid_out     <= 1'b0;
      bus.rs1_value_out <= '0;
      bus.rs2_value_out <= '0;
      bus.rd_sel_out    <= '0;
      bus.fwd_rs1_out   <= FWD_RF;
      bus.fwd_rs2_out   <= FWD_RF;
      rs1_q             <= '0;
      rs2_q             <= '0;
    end else if (bus.stall) begin
      bus.rs1_value_out <= rs1_val;
      bus.rs2_value_out <= rs2_val;
      bus.fwd_rs1_out   <= rs1_code;
      bus.fwd_rs2_out   <= rs2_code;
    end else begin
      bus.valid_out     <= bus.valid_in;
      bus.rs1_value_out <= rs1_val;
      bus.rs2_value_out <= rs2_val;
      bus.rd_sel_out    <= bus.rd_sel_in;
      bus.fwd_rs1_out   <= rs1_code;
      bus.fwd_rs2_out   <= rs2_code;
      rs1_q             <= bus.rs1_sel_in;
      rs2_q             <= bus.rs2_sel_in;
    end
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-side operand fetch for the CMPE 140 RISC-V pipeline. It holds the architectural register file, receives the writeback bus (enable, rd, value) driven by the execute-stage pipeline register, and reads two source operands per instruction. Operands are bypassed from the in-flight ALU result and from the writeback bus, then registered for the execute stage with stall and flush control.

## Interface
Parameters:
- XLEN, 32, data width
- REG_ADDR_W, 5, register select width (2^REG_ADDR_W registers)

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold decoded instruction; operands re-fetched
- flush  input  1  replace output with bubble
- valid_in  input  1  decoded instruction present
- rs1_sel_in, rs2_sel_in  input  REG_ADDR_W  source selects
- rd_sel_in  input  REG_ADDR_W  destination, passed through
- ex_write_enable, ex_rd_sel, ex_alu_result  input  1/REG_ADDR_W/XLEN  ALU-stage register outputs (in flight)
- wb_write_enable, wb_rd_sel, wb_value  input  1/REG_ADDR_W/XLEN  writeback bus
- valid_out  output  1  operand bundle valid
- rs1_value_out, rs2_value_out  output  XLEN  resolved operands
- rd_sel_out  output  REG_ADDR_W  registered destination
- fwd_rs1_out, fwd_rs2_out  output  2  source code of each operand

## Operation
- Register file: 32 x XLEN. Written at posedge when wb_write_enable=1 and wb_rd_sel!=0. x0 reads 0 and is never written.
- Writes occur regardless of stall/flush.
- Per-operand source select, priority high to low:
  - sel==0 -> 0, code FWD_ZERO
  - ex_write_enable and ex_rd_sel==sel -> ex_alu_result, FWD_EX
  - wb_write_enable and wb_rd_sel==sel -> wb_value, FWD_WB
  - else register file read, FWD_RF
- Internal held selects rs1_q/rs2_q capture rs1_sel_in/rs2_sel_in when !stall.
- Effective select = input select when !stall, held select when stall. This keeps a stalled operand current as producers move EX -> WB -> RF.
- Output update each posedge, by priority:
  - rst: clear everything
  - flush: valid_out=0; values, rd_sel_out and codes = 0; held selects = 0
  - stall: valid_out and rd_sel_out hold; rs*_value_out and fwd_* reload from the held selects
  - else: capture valid_in, rd_sel_in, and the resolved operands
- Flush with stall: flush wins.
- Select equality compares the full REG_ADDR_W bits. No arithmetic; all values pass through at XLEN width.

## Timing
- Latency: 1 cycle from inputs to outputs.
- Writeback is write-first. A value written in cycle N is seen combinationally via FWD_WB in cycle N and via FWD_RF from N+1.
- Reset (sync, rst=1 at posedge): all 32 registers = 0, valid_out=0, rs1/rs2_value_out=0, rd_sel_out=0, fwd_*=FWD_RF (2'b00), held selects = 0.
- rst asserted mid-stall: reset takes effect at that posedge and overrides stall and flush. A writeback in the same cycle is discarded.
- No combinational path from any input to any output.

## Structure
- Shared package cpu_pkg:
  - XLEN, REG_ADDR_W
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_EX=2'b10, FWD_ZERO=2'b11
- Sub-module regfile_2r1w: 2 asynchronous read ports, 1 synchronous write port, x0 hardwired to zero, synchronous reset clear.
- Bypass muxes and output register stay in operand_fetch_stage.

## Test plan
- Reset, then read x5 and x0 -> next cycle valid_out=0 and values 0. After valid_in=1 -> rs1=0, rs2=0, fwd_rs1=FWD_RF, fwd_rs2=FWD_ZERO.
- WB x3=0xDEADBEEF with rs1_sel=3 in the same cycle -> rs1_value_out=0xDEADBEEF, FWD_WB. Reread next cycle -> same value, FWD_RF.
- EX x7=0x11, WB x7=0x22, rs1=rs2=7 -> both outputs 0x11, FWD_EX (EX priority).
- WB to x0 with 0xFFFFFFFF, then read x0 -> 0, FWD_ZERO; register file unchanged.
- stall=1 with rs1=9, EX x9=0x55 -> output 0x55 FWD_EX. Next cycle the same result arrives on WB -> 0x55 FWD_WB. Next cycle -> 0x55 FWD_RF. valid_out and rd_sel_out are unchanged throughout.
- flush=1 and stall=1 with valid_in=1 -> valid_out=0 and values 0. Assert rst mid-stall -> all outputs and registers cleared on that edge.
